// File: rtl/decode_pkg.sv
// Shared defaults, field offsets and the immediate extension helper for the decode pipe.
package decode_pkg;

  localparam int INST_W_D = 16;
  localparam int OP_W_D   = 4;
  localparam int REG_W_D  = 4;
  localparam int IMM_W_D  = 8;
  localparam int DATA_W_D = 8;
  localparam int DEPTH_D  = 2;

  // Field offsets for the default word layout: op in the MSBs, then reg0..reg2.
  localparam int OP_LSB   = INST_W_D - OP_W_D;
  localparam int REG0_LSB = OP_LSB - REG_W_D;
  localparam int REG1_LSB = REG0_LSB - REG_W_D;
  localparam int REG2_LSB = REG1_LSB - REG_W_D;

  // Extend the low 'width' bits of val to 64 bits; callers truncate to their data width.
  function automatic logic [63:0] extend_imm(input logic [63:0] val,
                                             input int unsigned width,
                                             input logic sext);
    logic [63:0] mask;
    logic [63:0] res;
    mask = (64'd1 << width) - 64'd1;
    res  = val & mask;
    if (sext && val[width-1]) res = res | ~mask;
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == FULL_CT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and count update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/decode_pipe.sv
// Elastic instruction decoder: input FIFO with empty-bypass feeding a registered decode stage.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid,
// and a producer holding valid low-to-high may not see its word taken until that edge.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int                  INST_W      = INST_W_D,
  parameter int                  OP_W        = OP_W_D,
  parameter int                  REG_W       = REG_W_D,
  parameter int                  IMM_W       = IMM_W_D,
  parameter int                  DATA_W      = DATA_W_D,
  parameter int                  DEPTH       = DEPTH_D,
  parameter logic [2**OP_W-1:0]  SEXT_OPS    = 16'h0000,
  parameter logic [2**OP_W-1:0]  ILLEGAL_OPS = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INST_W-1:0]            inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_W-1:0]              op,
  output logic [REG_W-1:0]             reg0,
  output logic [REG_W-1:0]             reg1,
  output logic [REG_W-1:0]             reg2,
  output logic [IMM_W-1:0]             imm,
  output logic [DATA_W-1:0]            imm_ext,
  output logic                         illegal,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OP_LO = INST_W - OP_W;
  localparam int R0_LO = OP_LO - REG_W;
  localparam int R1_LO = R0_LO - REG_W;
  localparam int R2_LO = R1_LO - REG_W;

  logic              fifo_full;
  logic              fifo_empty;
  logic [INST_W-1:0] fifo_dout;
  logic              out_free;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              load;
  logic [INST_W-1:0] src;

  logic [OP_W-1:0]   op_d;
  logic [REG_W-1:0]  reg0_d;
  logic [REG_W-1:0]  reg1_d;
  logic [REG_W-1:0]  reg2_d;
  logic [IMM_W-1:0]  imm_d;
  logic [DATA_W-1:0] imm_ext_d;
  logic              illegal_d;

  assign in_ready  = !fifo_full;
  assign out_free  = !out_valid || out_ready;
  // An empty FIFO with a free output stage lets the word skip the buffer entirely.
  assign bypass    = fifo_empty && out_free && in_valid;
  assign fifo_push = in_valid && in_ready && !bypass;
  assign fifo_pop  = !fifo_empty && out_free;
  assign load      = fifo_pop || bypass;
  assign src       = fifo_pop ? fifo_dout : inst;

  sync_fifo #(
    .WIDTH (INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (inst),
    .dout  (fifo_dout),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fixed-slice field extraction and opcode classification of the word being loaded.
  always_comb begin
    op_d      = src[OP_LO +: OP_W];
    reg0_d    = src[R0_LO +: REG_W];
    reg1_d    = src[R1_LO +: REG_W];
    reg2_d    = src[R2_LO +: REG_W];
    imm_d     = src[IMM_W-1:0];
    imm_ext_d = DATA_W'(extend_imm(64'(imm_d), IMM_W, SEXT_OPS[op_d]));
    illegal_d = ILLEGAL_OPS[op_d];
  end

  // Output stage: load on pop/bypass, clear valid once consumed with nothing behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op        <= '0;
      reg0      <= '0;
      reg1      <= '0;
      reg2      <= '0;
      imm       <= '0;
      imm_ext   <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      op        <= op_d;
      reg0      <= reg0_d;
      reg1      <= reg1_d;
      reg2      <= reg2_d;
      imm       <= imm_d;
      imm_ext   <= imm_ext_d;
      illegal   <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe with a reference decode model and an expected queue.
module tb_decode_pipe;

  localparam int EXP_W = 4 + 4 + 4 + 4 + 8 + 12 + 1;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [3:0]  reg0;
  logic [3:0]  reg1;
  logic [3:0]  reg2;
  logic [7:0]  imm;
  logic [11:0] imm_ext;
  logic        illegal;
  logic [1:0]  occupancy;

  int tests_run    = 0;
  int tests_failed = 0;
  int rx_count     = 0;
  bit mon_en       = 0;
  bit stall_prev   = 0;
  logic [EXP_W-1:0] held;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] cur;

  decode_pipe #(
    .INST_W      (16),
    .OP_W        (4),
    .REG_W       (4),
    .IMM_W       (8),
    .DATA_W      (12),
    .DEPTH       (2),
    .SEXT_OPS    (16'h0010),
    .ILLEGAL_OPS (16'h8000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .reg0      (reg0),
    .reg1      (reg1),
    .reg2      (reg2),
    .imm       (imm),
    .imm_ext   (imm_ext),
    .illegal   (illegal),
    .occupancy (occupancy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur = {op, reg0, reg1, reg2, imm, imm_ext, illegal};

  // Reference decode: op 4 sign-extends, op F is illegal.
  function automatic logic [EXP_W-1:0] model(input logic [15:0] w);
    logic [7:0]  im;
    logic [11:0] ext;
    logic [3:0]  o;
    im = w[7:0];
    o  = w[15:12];
    if (o == 4'h4 && im[7]) ext = {4'hF, im};
    else                    ext = {4'h0, im};
    return {o, w[11:8], w[7:4], w[3:0], im, ext, (o == 4'hF)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n || flush) begin
        exp_q.delete();
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          tests_run++;
          if (!out_valid || cur !== held) begin
            tests_failed++;
            $display("FAIL stall_hold: got valid=%b fields=%h, need valid=1 fields=%h", out_valid, cur, held);
          end
        end
        if (out_valid && out_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_extra: got fields=%h, need no output", cur);
          end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            rx_count++;
            if (cur !== e) begin
              tests_failed++;
              $display("FAIL sb_data: got %h, need %h", cur, e);
            end
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(inst));
        stall_prev = out_valid && !out_ready;
        held       = cur;
      end
    end
  end

  task automatic test_reset();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; inst = '0;
    step(); step();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got valid=%b occ=%0d ready=%b, need 0 0 1", out_valid, occupancy, in_ready);
    end
    tests_run++;
    if (cur !== '0) begin
      tests_failed++;
      $display("FAIL reset_fields: got %h, need 0", cur);
    end
    rst_n = 1;
    mon_en = 1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1; in_valid = 1; inst = 16'h3A5F;
    step();
    in_valid = 0;
    tests_run++;
    if (out_valid !== 1'b1 || op !== 4'h3 || reg0 !== 4'hA || reg1 !== 4'h5 || reg2 !== 4'hF) begin
      tests_failed++;
      $display("FAIL basic_fields: got v=%b op=%h r=%h%h%h, need 1 3 A5F", out_valid, op, reg0, reg1, reg2);
    end
    tests_run++;
    if (imm !== 8'h5F || imm_ext !== 12'h05F || illegal !== 1'b0 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL basic_imm: got imm=%h ext=%h ill=%b occ=%0d, need 5F 05F 0 0", imm, imm_ext, illegal, occupancy);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drain: got valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_extend();
    logic [15:0] words [3];
    logic [11:0] exts  [3];
    words[0] = 16'h4080; exts[0] = 12'hF80;
    words[1] = 16'h5080; exts[1] = 12'h080;
    words[2] = 16'h407F; exts[2] = 12'h07F;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; inst = words[i];
      step();
      in_valid = 0;
      tests_run++;
      if (out_valid !== 1'b1 || imm_ext !== exts[i]) begin
        tests_failed++;
        $display("FAIL extend_%0d: got valid=%b ext=%h, need 1 %h", i, out_valid, imm_ext, exts[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    out_ready = 1; in_valid = 1; inst = 16'hF123;
    step();
    in_valid = 0;
    tests_run++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || op !== 4'hF || cur !== model(16'hF123)) begin
      tests_failed++;
      $display("FAIL illegal: got valid=%b ill=%b fields=%h, need 1 1 %h", out_valid, illegal, cur, model(16'hF123));
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [3];
    w[0] = 16'h1234; w[1] = 16'h2345; w[2] = 16'h3456;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; inst = w[i];
      step();
    end
    inst = 16'hDEAD;  // offered while full; must not be taken
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || cur !== model(w[0])) begin
      tests_failed++;
      $display("FAIL full_state: got occ=%0d ready=%b valid=%b fields=%h, need 2 0 1 %h",
               occupancy, in_ready, out_valid, cur, model(w[0]));
    end
    step(); step();
    in_valid = 0;
    tests_run++;
    if (cur !== model(w[0])) begin
      tests_failed++;
      $display("FAIL hold_first: got %h, need %h", cur, model(w[0]));
    end
    out_ready = 1;
    for (int i = 1; i < 3; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b1 || cur !== model(w[i]) || occupancy !== 2'(2 - i)) begin
        tests_failed++;
        $display("FAIL order_%0d: got valid=%b fields=%h occ=%0d, need 1 %h %0d",
                 i, out_valid, cur, occupancy, model(w[i]), 2 - i);
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_end: got valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; inst = 16'h1000 + 16'(i);
      step();
    end
    flush = 1; in_valid = 1; inst = 16'h7777;
    step();
    flush = 0; in_valid = 0;
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_full: got valid=%b occ=%0d ready=%b, need 0 0 1", out_valid, occupancy, in_ready);
    end
    out_ready = 1;
    step(); step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_residue: got valid=%b, need 0", out_valid);
    end
    flush = 1; in_valid = 1; inst = 16'h6666;
    step();
    flush = 0; in_valid = 0;
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_bypass: got valid=%b occ=%0d, need 0 0", out_valid, occupancy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; inst = 16'h2100 + 16'(i);
      step();
    end
    tests_run++;
    if (occupancy !== 2'd1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre: got occ=%0d valid=%b, need 1 1", occupancy, out_valid);
    end
    rst_n = 0; in_valid = 1; inst = 16'h4FFF;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || cur !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: got valid=%b occ=%0d fields=%h ready=%b, need 0 0 0 1",
               out_valid, occupancy, cur, in_ready);
    end
    rst_n = 1; in_valid = 0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_after: got valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc  = 0;
    int rx0;
    rx0 = rx_count;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inst      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() != 0 || out_valid) step();
    end
    tests_run++;
    if (sent != 1000) begin
      tests_failed++;
      $display("FAIL rand_budget: got %0d words sent, need 1000", sent);
    end
    tests_run++;
    if (rx_count - rx0 != 1000 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d received, %0d pending, need 1000 0", rx_count - rx0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extend();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, elastic instruction decoder. Successor to the fixed 16-bit enable-strobed decoder.
- Accepts raw instruction words over a valid/ready handshake and buffers them in a small FIFO (depth DEPTH).
- Splits each word into opcode, register and immediate fields, and classifies the opcode (sign-extend, illegal).
- Presents the result in a registered output stage with its own valid/ready handshake. Sits between the fetch unit and the execute/register-read stage.

Parameters:
- INST_W, 16, instruction word width; must be >= OP_W + 3*REG_W.
- OP_W, 4, opcode field width, taken from the MSBs.
- REG_W, 4, width of each register-index field.
- IMM_W, 8, immediate/address field width, taken from the LSBs; must be <= INST_W - OP_W - REG_W.
- DATA_W, 8, width of the extended immediate; must be >= IMM_W.
- DEPTH, 2, input FIFO entries; power of two, >= 1.
- SEXT_OPS, 16'h0000, bitmask over the 2**OP_W opcodes; bit k set means opcode k sign-extends its immediate.
- ILLEGAL_OPS, 16'h0000, bitmask over opcodes; bit k set means opcode k is flagged illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous: discard all buffered and output-stage instructions.
- in_valid  in  1  inst is valid.
- in_ready  out  1  FIFO can accept a word.
- inst  in  INST_W  raw instruction word.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  consumer accepts the decoded fields.
- op  out  OP_W  inst[INST_W-1 -: OP_W].
- reg0  out  REG_W  next REG_W bits below op.
- reg1  out  REG_W  next REG_W bits below reg0.
- reg2  out  REG_W  next REG_W bits below reg1.
- imm  out  IMM_W  inst[IMM_W-1:0]; also serves as the address field.
- imm_ext  out  DATA_W  imm sign-extended if SEXT_OPS[op], else zero-extended.
- illegal  out  1  ILLEGAL_OPS[op].
- occupancy  out  clog2(DEPTH+1)  FIFO entry count; excludes the output stage.

Behaviour:
- Reset (rst_n low at a clk edge) clears the FIFO pointers and occupancy to 0 and sets out_valid to 0. op, reg0-2, imm, imm_ext and illegal reset to 0. A reset during operation drops everything held, including a word being accepted in that cycle.
- in_ready = (occupancy != DEPTH). It is combinational from state only and never depends on in_valid.
- Push occurs when in_valid && in_ready. Pop occurs when the FIFO is non-empty and the output stage is free (!out_valid || out_ready).
- Pop loads the decoded fields of the FIFO head into the output registers and sets out_valid. If the output stage is freed and nothing is popped, out_valid clears.
- Bypass: when the FIFO is empty and the output stage is free, a pushed word goes straight to the output stage. In that case out_valid rises the cycle after acceptance (latency 1) and occupancy stays 0.
- Simultaneous push and pop on a full FIFO is not allowed: in_ready is already 0 when full.
- Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- Pointers wrap modulo DEPTH.
- While out_valid && !out_ready, all output fields hold stable.
- Field extraction uses fixed slicing, independent of op. Bits between reg2 and imm are ignored.
- imm_ext is computed at pop time and registered together with the other fields.
- flush has priority over push and pop. It empties the FIFO and clears out_valid on the next edge. A word presented in the same cycle as flush is discarded. rst_n has priority over flush.
- illegal words are not dropped; they pass through with illegal=1.

Decomposition:
- Shared package decode_pkg:
  - default field widths and the field-offset localparams (OP_LSB, REG0_LSB, REG1_LSB, REG2_LSB);
  - a function for the sign/zero-extension.
- Sub-module sync_fifo (clk, rst_n, flush, push, pop, din, dout, count, full, empty), parametrised by WIDTH and DEPTH and reused by fetch.
- The decode logic and output stage live in decode_pipe.

Test Plan:
- Default parameters, reset, then push 16'h3A5F with out_ready=1. Required: out_valid=1 one cycle later, op=3, reg0=A, reg1=5, reg2=F, imm=5F, imm_ext=5F, illegal=0, occupancy=0.
- SEXT_OPS=16'h0010, push 16'h4080. Required: imm_ext=8'h80. With DATA_W=12: imm_ext=12'hF80. Push 16'h5080: imm_ext=12'h080.
- ILLEGAL_OPS=16'h8000, push 16'hF123. Required: illegal=1, word delivered normally with op=F.
- out_ready=0, push 3 words with DEPTH=2. Required: first word held stable in the output stage, occupancy=2, in_ready=0. Release out_ready: words emerge in order on consecutive cycles.
- Full pipe plus flush=1 with in_valid=1. Required: next cycle out_valid=0, occupancy=0, in_ready=1, flushed-cycle word never appears.
- Assert rst_n=0 mid-stream with occupancy=1 and out_valid=1. Required: all outputs 0 next cycle. Random valid/ready with a scoreboard over 1000 words: no loss, no duplication, order preserved.
